// File: rtl/rf_access_sequencer_pkg.sv
// Shared definitions for the register-file access sequencer:
// widths, opcode and state encodings, command record and write-gating helper.
package rf_access_sequencer_pkg;

    localparam int unsigned DATA_MSB = 31;
    localparam int unsigned ADDR_MSB = 4;

    typedef logic [DATA_MSB:0] data_t;
    typedef logic [ADDR_MSB:0] addr_t;

    typedef enum logic [1:0] {
        OP_NOP        = 2'b00,
        OP_READ       = 2'b01,
        OP_WRITE      = 2'b10,
        OP_WRITE_READ = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR         = 3'd1,
        S_RD_ISSUE   = 3'd2,
        S_RD_CAPTURE = 3'd3,
        S_RESP       = 3'd4
    } state_e;

    typedef struct packed {
        op_e   op;
        addr_t rs;
        addr_t rt;
        addr_t rd;
        data_t wdata;
    } cmd_t;

    // Register 0 is read-only when zero protection is enabled.
    function automatic logic write_allowed(input int unsigned zero_protect, input addr_t rd);
        return (zero_protect == 0) || (rd != '0);
    endfunction

endpackage

// File: rtl/rf_access_sequencer.sv
// Sequences a single latched command into register-file write/read strobes
// and returns a one-cycle completion pulse with captured read data.
module rf_access_sequencer
    import rf_access_sequencer_pkg::*;
#(
    parameter int unsigned ZERO_PROTECT = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [1:0]          CMD_OP,
    input  logic [ADDR_MSB:0]   CMD_RS,
    input  logic [ADDR_MSB:0]   CMD_RT,
    input  logic [ADDR_MSB:0]   CMD_RD,
    input  logic [DATA_MSB:0]   CMD_WDATA,
    output logic                RESP_VALID,
    output logic [DATA_MSB:0]   RESP_RS_DATA,
    output logic [DATA_MSB:0]   RESP_RT_DATA,
    output logic                RF_READ,
    output logic                RF_WRITE,
    output logic [ADDR_MSB:0]   RF_ADDR_R1,
    output logic [ADDR_MSB:0]   RF_ADDR_R2,
    output logic [ADDR_MSB:0]   RF_ADDR_W,
    output logic [DATA_MSB:0]   RF_DATA_W,
    input  logic [DATA_MSB:0]   RF_DATA_R1,
    input  logic [DATA_MSB:0]   RF_DATA_R2
);

    state_e state_q, state_d;
    cmd_t   cmd_q, cmd_d;

    logic   cmd_ready_q, cmd_ready_d;
    logic   resp_valid_q, resp_valid_d;
    data_t  resp_rs_q, resp_rs_d;
    data_t  resp_rt_q, resp_rt_d;
    logic   rf_read_q, rf_read_d;
    logic   rf_write_q, rf_write_d;
    addr_t  addr_r1_q, addr_r1_d;
    addr_t  addr_r2_q, addr_r2_d;
    addr_t  addr_w_q, addr_w_d;
    data_t  data_w_q, data_w_d;

    logic   accept;

    assign accept = CMD_VALID && cmd_ready_q && (state_q == S_IDLE);

    // Outputs are registered from the next state and next command, so each
    // strobe lines up with the state it belongs to without a decode stage.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        resp_rs_d    = resp_rs_q;
        resp_rt_d    = resp_rt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cmd_d.op    = op_e'(CMD_OP);
                    cmd_d.rs    = CMD_RS;
                    cmd_d.rt    = CMD_RT;
                    cmd_d.rd    = CMD_RD;
                    cmd_d.wdata = CMD_WDATA;
                    case (op_e'(CMD_OP))
                        OP_NOP:  state_d = S_RESP;
                        OP_READ: state_d = S_RD_ISSUE;
                        default: state_d = S_WR;
                    endcase
                end
            end
            S_WR:         state_d = (cmd_q.op == OP_WRITE_READ) ? S_RD_ISSUE : S_RESP;
            S_RD_ISSUE:   state_d = S_RD_CAPTURE;
            S_RD_CAPTURE: begin
                state_d   = S_RESP;
                resp_rs_d = RF_DATA_R1;
                resp_rt_d = RF_DATA_R2;
            end
            S_RESP:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase

        cmd_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        rf_read_d    = (state_d == S_RD_ISSUE) || (state_d == S_RD_CAPTURE);
        rf_write_d   = (state_d == S_WR) && write_allowed(ZERO_PROTECT, cmd_d.rd);
        addr_r1_d    = rf_read_d ? cmd_d.rs : '0;
        addr_r2_d    = rf_read_d ? cmd_d.rt : '0;
        addr_w_d     = rf_write_d ? cmd_d.rd : '0;
        data_w_d     = rf_write_d ? cmd_d.wdata : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            cmd_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rs_q    <= '0;
            resp_rt_q    <= '0;
            rf_read_q    <= 1'b0;
            rf_write_q   <= 1'b0;
            addr_r1_q    <= '0;
            addr_r2_q    <= '0;
            addr_w_q     <= '0;
            data_w_q     <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rs_q    <= resp_rs_d;
            resp_rt_q    <= resp_rt_d;
            rf_read_q    <= rf_read_d;
            rf_write_q   <= rf_write_d;
            addr_r1_q    <= addr_r1_d;
            addr_r2_q    <= addr_r2_d;
            addr_w_q     <= addr_w_d;
            data_w_q     <= data_w_d;
        end
    end

    assign CMD_READY    = cmd_ready_q;
    assign RESP_VALID   = resp_valid_q;
    assign RESP_RS_DATA = resp_rs_q;
    assign RESP_RT_DATA = resp_rt_q;
    assign RF_READ      = rf_read_q;
    assign RF_WRITE     = rf_write_q;
    assign RF_ADDR_R1   = addr_r1_q;
    assign RF_ADDR_R2   = addr_r2_q;
    assign RF_ADDR_W    = addr_w_q;
    assign RF_DATA_W    = data_w_q;

endmodule

// File: doc/rf_access_sequencer.md
RF_ACCESS_SEQUENCER -- requirements
Module: rf_access_sequencer

Interface
REQ-001 The block SHALL have parameter ZERO_PROTECT, default 1; when 1, writes to register address 0 are suppressed.
REQ-002 The block SHALL have port CLK, input, 1 bit: single clock; all state updates on +ve edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-low, acting at -ve edge.
REQ-004 The block SHALL have ports CMD_VALID in 1 and CMD_READY out 1: command handshake; a command is accepted on a CLK edge with both high.
REQ-005 The block SHALL have port CMD_OP, input, 2 bits: 00 NOP, 01 READ, 10 WRITE, 11 WRITE_THEN_READ.
REQ-006 The block SHALL have ports CMD_RS and CMD_RT in 5 (read addresses), CMD_RD in 5 (write address), CMD_WDATA in 32 (write data).
REQ-007 The block SHALL have port RESP_VALID, output, 1 bit: one-cycle completion pulse.
REQ-008 The block SHALL have ports RESP_RS_DATA and RESP_RT_DATA, output, 32 bits each: captured read data.
REQ-009 The block SHALL have ports RF_READ and RF_WRITE, output, 1 bit each: register-file read/write strobes.
REQ-010 The block SHALL have ports RF_ADDR_R1, RF_ADDR_R2 and RF_ADDR_W out 5, RF_DATA_W out 32, and RF_DATA_R1, RF_DATA_R2 in 32: register-file address and data bus.

Function
REQ-011 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_CAPTURE, RESP; CMD_READY=1 only in IDLE.
REQ-012 On acceptance, the command SHALL be latched into internal registers; CMD_* are ignored afterwards until IDLE.
REQ-013 IDLE transitions SHALL be: OP=00 -> RESP; OP=01 -> RD_ISSUE; OP=10 or 11 -> WR.
REQ-014 WR SHALL last one cycle with RF_WRITE=1, RF_READ=0, RF_ADDR_W=RD, RF_DATA_W=WDATA; the next state is RESP for OP=10 and RD_ISSUE for OP=11.
REQ-015 With ZERO_PROTECT=1 and RD=0, WR SHALL still occupy one cycle but hold RF_WRITE=0.
REQ-016 RD_ISSUE and RD_CAPTURE SHALL each last one cycle with RF_READ=1, RF_WRITE=0, RF_ADDR_R1=RS, RF_ADDR_R2=RT.
REQ-017 At the end of RD_CAPTURE, RF_DATA_R1 and RF_DATA_R2 SHALL be sampled into RESP_RS_DATA and RESP_RT_DATA; RD_CAPTURE then goes to RESP.
REQ-018 RESP SHALL assert RESP_VALID for exactly one cycle and then return to IDLE; RESP_*_DATA SHALL hold until the next read capture.
REQ-019 NOP and WRITE responses SHALL leave RESP_*_DATA unchanged.
REQ-020 RF_READ and RF_WRITE SHALL never be 1 simultaneously, and both SHALL be 0 in IDLE and RESP.
REQ-021 Latency from acceptance edge to RESP_VALID high SHALL be: NOP 1 cycle, WRITE 2, READ 3, WRITE_THEN_READ 4.
REQ-022 A new command SHALL be acceptable on the edge after RESP; back-to-back throughput for READ is therefore one command per 4 cycles.
REQ-023 All outputs SHALL be registered, with no combinational path from CMD_* to RF_*.
REQ-024 An illegal or X state SHALL recover to IDLE on the next edge.

Reset
REQ-025 RST low SHALL immediately force IDLE, CMD_READY=1, RESP_VALID=0, RF_READ=0, RF_WRITE=0, all RF address/data outputs=0, and RESP_*_DATA=0.
REQ-026 A reset arriving mid-command SHALL abort the command, and no RF strobe SHALL be asserted after RST falls.
REQ-027 The first command SHALL be accepted on the first CLK edge with RST high and CMD_VALID=1.

Structure
REQ-028 Opcode values, state encodings and the width limits (data index 31, register address index 4) SHALL live in the shared definitions include.
REQ-029 The block SHALL be a single module with no sub-module; the register file is instantiated only in the bench.

Verification
REQ-030 Bench scenario: reset the register file (contents reg[i]=i), then READ RS=3 RT=5 -> RESP_VALID 3 cycles after acceptance with RS_DATA=3 and RT_DATA=5.
REQ-031 Bench scenario: WRITE RD=7 WDATA=0xDEADBEEF, then READ RS=7 RT=0 -> RS_DATA=0xDEADBEEF, RT_DATA=0.
REQ-032 Bench scenario: WRITE_THEN_READ RD=RS=9 WDATA=0x12345678 RT=2 -> after 4 cycles RS_DATA=0x12345678 and RT_DATA=2; RF_WRITE pulse precedes RF_READ.
REQ-033 Bench scenario: ZERO_PROTECT=1, WRITE RD=0 WDATA=0xFFFFFFFF, then READ RS=0 -> RS_DATA=0, and RF_WRITE never high.
REQ-034 Bench scenario: assert RST low during RD_ISSUE of a READ -> outputs are at reset values immediately, there is no RESP_VALID, and the next READ RS=4 returns 4.
REQ-035 Bench scenario: hold CMD_VALID high continuously with NOP/READ alternating -> CMD_READY pattern is 1,0,1,0,0,0,1 and every command gets exactly one RESP_VALID.
